model_trainer_vector_differentiation: RTL and testbench

// - Streaming temporal differentiator for the NTM trainer: dy[i] = (x_t[i] - x_{t-1}[i]) >>> SHIFT_IN.
// - Consumes one element per accepted beat and produces the derivative beat for the differentiation stage.
// - Keeps the previous vector in an internal buffer.
// - The first vector after reset, or after a size change, yields zeros.
//

---
 rtl/model_trainer_differentiation_pkg.sv | 29 ++
 rtl/model_trainer_differentiation_buffer.sv | 23 ++
 rtl/model_trainer_vector_differentiation.sv | 129 ++++++++++++
 tb/tb_model_trainer_vector_differentiation.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/model_trainer_differentiation_pkg.sv
// Shared constants, state encoding and saturation helper for the streaming
// temporal differentiator.
package model_trainer_differentiation_pkg;

   localparam int DATA_SIZE    = 64;
   localparam int CONTROL_SIZE = 64;
   localparam int MAX_SIZE     = 64;
   localparam int SHIFT_W      = 6;
   localparam int ADDR_W       = $clog2(MAX_SIZE);
   localparam int SIZE_W       = $clog2(MAX_SIZE + 1);

   localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

   typedef enum logic [1:0] {
      STARTER,
      INPUT_STATE,
      ENDER
   } differentiation_state_t;

   // q is a DATA_SIZE+1 bit two's complement value; it overflows the output
   // width exactly when its top two bits disagree.
   function automatic logic [DATA_SIZE-1:0] saturate(input logic [DATA_SIZE:0] q);
      if (q[DATA_SIZE] != q[DATA_SIZE-1])
         return q[DATA_SIZE] ? SAT_MIN : SAT_MAX;
      return q[DATA_SIZE-1:0];
   endfunction

endpackage

// File: rtl/model_trainer_differentiation_buffer.sv
// Previous-vector store: MAX_SIZE x DATA_SIZE, synchronous write, asynchronous
// read, so a same-index read in the write cycle sees the old contents.
module model_trainer_differentiation_buffer
   import model_trainer_differentiation_pkg::*;
(
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_SIZE-1:0] wr_data,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic [DATA_SIZE-1:0] rd_data
);

   logic [DATA_SIZE-1:0] mem [MAX_SIZE];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/model_trainer_vector_differentiation.sv
// Streaming temporal differentiator: dy[i] = sat((x_t[i] - x_{t-1}[i]) >>> shift),
// one element per accepted beat, previous vector kept in a local buffer.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// STARTER     | idle, waiting for START; latches size and shift
// INPUT_STATE | DATA_ENABLE high, one element consumed per DATA_IN_ENABLE
// ENDER       | READY pulse, record size and mark the buffer as primed
module model_trainer_vector_differentiation
   import model_trainer_differentiation_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic [CONTROL_SIZE-1:0] SIZE_IN,
   input  logic [SHIFT_W-1:0]      SHIFT_IN,
   input  logic                    DATA_IN_ENABLE,
   output logic                    DATA_ENABLE,
   input  logic [DATA_SIZE-1:0]    DATA_IN,
   output logic                    DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]    DATA_OUT
);

   differentiation_state_t state;

   logic [SIZE_W-1:0]    size_r;
   logic [SIZE_W-1:0]    last_size;
   logic [SHIFT_W-1:0]   shift_r;
   logic [ADDR_W-1:0]    index;
   logic                 primed;
   logic                 primed_use;
   logic                 ready_r;
   logic                 data_enable_r;
   logic                 data_out_enable_r;
   logic [DATA_SIZE-1:0] data_out_r;

   logic                 beat;
   logic                 last_beat;
   logic [SIZE_W-1:0]    size_clamped;
   logic [DATA_SIZE-1:0] prev_elem;
   logic [DATA_SIZE:0]   diff;
   logic [DATA_SIZE:0]   shifted;
   logic [DATA_SIZE-1:0] result;

   assign beat      = (state == INPUT_STATE) && DATA_IN_ENABLE;
   assign last_beat = (SIZE_W'(index) == size_r - SIZE_W'(1));

   always_comb begin
      size_clamped = SIZE_IN[SIZE_W-1:0];
      if (SIZE_IN > CONTROL_SIZE'(MAX_SIZE))
         size_clamped = SIZE_W'(MAX_SIZE);
   end

   model_trainer_differentiation_buffer u_buffer (
      .clk     (CLK),
      .wr_en   (beat),
      .wr_addr (index),
      .wr_data (DATA_IN),
      .rd_addr (index),
      .rd_data (prev_elem)
   );

   // One extra bit keeps the full-range difference exact before the shift.
   assign diff    = {DATA_IN[DATA_SIZE-1], DATA_IN} - {prev_elem[DATA_SIZE-1], prev_elem};
   assign shifted = $unsigned($signed(diff) >>> shift_r);
   assign result  = primed_use ? saturate(shifted) : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state             <= STARTER;
         size_r            <= '0;
         last_size         <= '0;
         shift_r           <= '0;
         index             <= '0;
         primed            <= 1'b0;
         primed_use        <= 1'b0;
         ready_r           <= 1'b0;
         data_enable_r     <= 1'b0;
         data_out_enable_r <= 1'b0;
         data_out_r        <= '0;
      end else begin
         ready_r           <= 1'b0;
         data_out_enable_r <= 1'b0;
         case (state)
            STARTER: begin
               if (START) begin
                  size_r     <= size_clamped;
                  shift_r    <= SHIFT_IN;
                  index      <= '0;
                  primed_use <= primed && (size_clamped == last_size);
                  if (size_clamped == '0) begin
                     state   <= ENDER;
                     ready_r <= 1'b1;
                  end else begin
                     state         <= INPUT_STATE;
                     data_enable_r <= 1'b1;
                  end
               end
            end
            INPUT_STATE: begin
               if (beat) begin
                  data_out_enable_r <= 1'b1;
                  data_out_r        <= result;
                  if (last_beat) begin
                     state         <= ENDER;
                     data_enable_r <= 1'b0;
                     ready_r       <= 1'b1;
                  end else begin
                     index <= index + ADDR_W'(1);
                  end
               end
            end
            ENDER: begin
               primed    <= 1'b1;
               last_size <= size_r;
               state     <= STARTER;
            end
            default: state <= STARTER;
         endcase
      end
   end

   assign READY           = ready_r;
   assign DATA_ENABLE     = data_enable_r;
   assign DATA_OUT_ENABLE = data_out_enable_r;
   assign DATA_OUT        = data_out_r;

endmodule

// File: tb/tb_model_trainer_vector_differentiation.sv
// Directed, table-driven bench for the streaming differentiator, with
// hand-written sequences for zero-size vectors and reset mid-vector.
module tb_model_trainer_vector_differentiation;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        READY;
   logic [63:0] SIZE_IN;
   logic [5:0]  SHIFT_IN;
   logic        DATA_IN_ENABLE;
   logic        DATA_ENABLE;
   logic [63:0] DATA_IN;
   logic        DATA_OUT_ENABLE;
   logic [63:0] DATA_OUT;

   localparam logic [63:0] MAXV = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   typedef struct packed {
      logic [7:0]        size;
      logic [5:0]        shift;
      logic              junk;
      logic              mid_start;
      logic [3:0][63:0]  din;
      logic [3:0][63:0]  expv;
      logic [3:0][3:0]   gap;
   } vec_t;

   vec_t tbl [16];
   int   n_vec = 0;
   int   tests = 0;
   int   fails = 0;
   int   doe_cnt = 0;
   int   ready_cnt = 0;

   model_trainer_vector_differentiation dut (
      .CLK             (CLK),
      .RST             (RST),
      .START           (START),
      .READY           (READY),
      .SIZE_IN         (SIZE_IN),
      .SHIFT_IN        (SHIFT_IN),
      .DATA_IN_ENABLE  (DATA_IN_ENABLE),
      .DATA_ENABLE     (DATA_ENABLE),
      .DATA_IN         (DATA_IN),
      .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
      .DATA_OUT        (DATA_OUT)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (DATA_OUT_ENABLE) doe_cnt++;
      if (READY) ready_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int size, input int shift, input bit junk, input bit mid,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [63:0] d3,
                      input logic [63:0] e0, input logic [63:0] e1,
                      input logic [63:0] e2, input logic [63:0] e3,
                      input int g0, input int g1, input int g2, input int g3);
      vec_t v;
      v.size = 8'(size);      v.shift = 6'(shift);
      v.junk = junk;          v.mid_start = mid;
      v.din[0] = d0; v.din[1] = d1; v.din[2] = d2; v.din[3] = d3;
      v.expv[0] = e0; v.expv[1] = e1; v.expv[2] = e2; v.expv[3] = e3;
      v.gap[0] = 4'(g0); v.gap[1] = 4'(g1); v.gap[2] = 4'(g2); v.gap[3] = 4'(g3);
      tbl[n_vec] = v;
      n_vec++;
   endtask

   // Entered and left at 1 time unit after a rising edge, DUT in STARTER.
   task automatic run_vec(input vec_t v, input int id);
      int d0 = doe_cnt;
      int r0 = ready_cnt;
      if (v.junk) begin
         DATA_IN_ENABLE = 1'b1;
         DATA_IN = 64'h5555_AAAA_5555_AAAA;
         repeat (2) @(posedge CLK);
         #1;
         DATA_IN_ENABLE = 1'b0;
         chk($sformatf("v%0d idle_in_ignored", id), 64'(doe_cnt - d0), 64'd0);
      end
      START = 1'b1;
      SIZE_IN = 64'(v.size);
      SHIFT_IN = v.shift;
      @(posedge CLK); #1;
      START = 1'b0;
      SIZE_IN = 64'd7;
      SHIFT_IN = 6'd5;
      for (int i = 0; i < int'(v.size); i++) begin
         for (int g = 0; g < int'(v.gap[i]); g++) begin
            @(posedge CLK); #1;
         end
         chk($sformatf("v%0d[%0d] data_enable", id, i), 64'(DATA_ENABLE), 64'd1);
         DATA_IN_ENABLE = 1'b1;
         DATA_IN = v.din[i];
         if (v.mid_start && i == 0) begin
            START = 1'b1;
            SIZE_IN = 64'd1;
         end
         @(posedge CLK); #1;
         DATA_IN_ENABLE = 1'b0;
         START = 1'b0;
         chk($sformatf("v%0d[%0d] out_enable", id, i), 64'(DATA_OUT_ENABLE), 64'd1);
         chk($sformatf("v%0d[%0d] data_out", id, i), DATA_OUT, v.expv[i]);
         chk($sformatf("v%0d[%0d] ready", id, i), 64'(READY),
             (i == int'(v.size) - 1) ? 64'd1 : 64'd0);
      end
      @(posedge CLK); #1;
      chk($sformatf("v%0d out_count", id), 64'(doe_cnt - d0), 64'(v.size));
      chk($sformatf("v%0d ready_count", id), 64'(ready_cnt - r0), 64'd1);
      chk($sformatf("v%0d data_enable_end", id), 64'(DATA_ENABLE), 64'd0);
   endtask

   initial begin
      int d0, r0;
      RST = 1'b1; START = 1'b0; SIZE_IN = '0; SHIFT_IN = '0;
      DATA_IN_ENABLE = 1'b0; DATA_IN = '0;

      add(4, 0, 0, 0, 1, 2, 3, 4,       0, 0, 0, 0,    0, 0, 0, 0);
      add(4, 1, 0, 0, 5, 2, -1, 10,     2, 0, -2, 3,   0, 0, 0, 0);
      add(3, 0, 0, 0, 7, 7, 7, 0,       0, 0, 0, 0,    0, 1, 0, 0);
      add(3, 0, 1, 0, 10, 5, 7, 0,      3, -2, 0, 0,   2, 0, 3, 0);
      add(3, 2, 0, 1, -10, 25, 7, 0,    -5, 5, 0, 0,   0, 0, 0, 0);
      add(1, 0, 0, 0, MINV, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 0);
      add(1, 0, 0, 0, MAXV, 0, 0, 0,    MAXV, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, MINV, 0, 0, 0,    MINV, 0, 0, 0, 0, 0, 0, 0);
      add(1, 63, 0, 0, MAXV, 0, 0, 0,   1, 0, 0, 0,    0, 0, 0, 0);
      add(1, 2, 0, 0, MINV, 0, 0, 0,    64'hC000_0000_0000_0000, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 42, 0, 0, 0,      0, 0, 0, 0,    0, 0, 0, 0);
      add(4, 0, 0, 0, 1, 1, 1, 1,       0, 0, 0, 0,    0, 0, 0, 0);
      add(4, 0, 0, 0, 3, 3, 3, 3,       0, 0, 0, 0,    0, 0, 0, 0);

      repeat (2) @(posedge CLK);
      #1;
      chk("reset ready", 64'(READY), 64'd0);
      chk("reset data_enable", 64'(DATA_ENABLE), 64'd0);
      chk("reset out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
      chk("reset data_out", DATA_OUT, 64'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      for (int k = 0; k < 10; k++) run_vec(tbl[k], k);

      // Zero-length vector: straight to ENDER, READY with no elements.
      d0 = doe_cnt; r0 = ready_cnt;
      START = 1'b1; SIZE_IN = 64'd0; SHIFT_IN = 6'd0;
      @(posedge CLK); #1;
      START = 1'b0;
      chk("size0 ready", 64'(READY), 64'd1);
      chk("size0 data_enable", 64'(DATA_ENABLE), 64'd0);
      @(posedge CLK); #1;
      chk("size0 ready_drop", 64'(READY), 64'd0);
      chk("size0 out_count", 64'(doe_cnt - d0), 64'd0);
      chk("size0 ready_count", 64'(ready_cnt - r0), 64'd1);

      run_vec(tbl[10], 10);
      run_vec(tbl[11], 11);

      // Reset after two of four beats of a primed vector.
      r0 = ready_cnt;
      START = 1'b1; SIZE_IN = 64'd4; SHIFT_IN = 6'd0;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int i = 0; i < 2; i++) begin
         DATA_IN_ENABLE = 1'b1; DATA_IN = 64'd9;
         @(posedge CLK); #1;
         chk($sformatf("pre_reset[%0d] data_out", i), DATA_OUT, 64'd8);
      end
      DATA_IN_ENABLE = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      chk("mid_reset out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
      chk("mid_reset data_out", DATA_OUT, 64'd0);
      chk("mid_reset data_enable", 64'(DATA_ENABLE), 64'd0);
      chk("mid_reset ready", 64'(READY), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      chk("mid_reset no_ready", 64'(ready_cnt - r0), 64'd0);

      run_vec(tbl[12], 12);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
